// File: rtl/fcvt_w_pipe.sv
// fcvt_w_pipe: two-register pipelined FCVT.W.S / FCVT.WU.S stage.
// S1 holds the accepted operand. The float-to-integer conversion is
// combinational between S1 and S2. S2 drives the writeback outputs.
module fcvt_w_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op,
    input  logic [2:0]       in_rm,
    input  logic [2:0]       in_frm,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_fflags,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    logic             s1_valid;
    logic             s2_valid;
    logic [31:0]      s1_op;
    logic [2:0]       s1_rm;
    logic             s1_uns;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_free;
    logic             s1_move;
    logic             accept;
    logic [2:0]       in_eff_rm;

    assign s2_free   = !s2_valid || out_ready;
    assign s1_move   = s1_valid && s2_free;
    assign in_ready  = !s1_valid || s2_free;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign in_eff_rm = (in_rm == RM_DYN) ? in_frm : in_rm;

    // Operand fields of the op sitting in S1
    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_man;

    assign op_sign = s1_op[31];
    assign op_exp  = s1_op[30:23];
    assign op_man  = s1_op[22:0];

    // Shift amount for 0 <= E <= 31: (exp - 127) mod 32 equals exp[4:0] + 1
    logic [4:0] e_sh;
    assign e_sh = op_exp[4:0] + 5'd1;

    // Magnitude core: rounding mode folded onto the sign-stripped operand
    logic [2:0]  core_rm;
    logic [54:0] shifted;
    logic [31:0] int_part;
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [31:0] core_mag;

    // Map the resolved rounding mode onto magnitude rounding and round the integer part
    always_comb begin
        core_rm = RM_RTZ;
        case (s1_rm)
            RM_RNE:  core_rm = RM_RNE;
            RM_RTZ:  core_rm = RM_RTZ;
            RM_RDN:  core_rm = op_sign ? RM_RUP : RM_RTZ;
            RM_RUP:  core_rm = op_sign ? RM_RTZ : RM_RUP;
            RM_RMM:  core_rm = RM_RMM;
            default: core_rm = RM_RTZ;
        endcase

        shifted  = {31'd0, 1'b1, op_man} << e_sh;
        int_part = shifted[54:23];
        frac     = shifted[22:0];
        guard    = frac[22];
        sticky   = |frac[21:0];

        round_up = 1'b0;
        case (core_rm)
            RM_RNE:  round_up = guard && (sticky || int_part[0]);
            RM_RUP:  round_up = guard || sticky;
            RM_RMM:  round_up = guard;
            default: round_up = 1'b0;
        endcase

        core_mag = int_part + {31'd0, round_up};
    end

    // Special-case classification and final result selection
    logic        is_illegal;
    logic        is_nan;
    logic        is_zero;
    logic        is_small;
    logic        is_big;
    logic        is_e31;
    logic        small_up;
    logic [31:0] mag;
    logic        mag_inexact;
    logic [31:0] conv_result;
    logic [4:0]  conv_fflags;
    logic        conv_illegal;
    logic        nv;
    logic        nx;

    // Apply sign, saturation, unsigned-negative and exception-flag rules
    always_comb begin
        is_illegal = (s1_rm == 3'b101) || (s1_rm == 3'b110) || (s1_rm == 3'b111);
        is_nan     = (op_exp == 8'hFF) && (op_man != 23'd0);
        is_zero    = (op_exp == 8'd0) && (op_man == 23'd0);
        is_small   = op_exp < 8'd127;
        is_big     = op_exp >= 8'd159;
        is_e31     = op_exp == 8'd158;

        small_up = 1'b0;
        if (op_exp == 8'd0) begin
            small_up = (core_rm == RM_RUP);
        end else if (op_exp == 8'd126) begin
            case (core_rm)
                RM_RNE:  small_up = (op_man != 23'd0);
                RM_RMM:  small_up = 1'b1;
                RM_RUP:  small_up = 1'b1;
                default: small_up = 1'b0;
            endcase
        end else begin
            small_up = (core_rm == RM_RUP);
        end

        mag         = is_small ? {31'd0, small_up} : core_mag;
        mag_inexact = is_small ? 1'b1 : (|frac);

        conv_result  = 32'd0;
        conv_illegal = 1'b0;
        nv           = 1'b0;
        nx           = 1'b0;

        if (is_illegal) begin
            conv_illegal = 1'b1;
        end else if (is_nan) begin
            conv_result = s1_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            nv          = 1'b1;
        end else if (is_zero) begin
            conv_result = 32'd0;
        end else if (!s1_uns) begin
            if (!op_sign) begin
                if (op_exp >= 8'd158) begin
                    conv_result = 32'h7FFF_FFFF;
                    nv          = 1'b1;
                end else begin
                    conv_result = mag;
                    nx          = mag_inexact;
                end
            end else begin
                if (is_big || (is_e31 && (op_man != 23'd0))) begin
                    conv_result = 32'h8000_0000;
                    nv          = 1'b1;
                end else begin
                    conv_result = 32'd0 - mag;
                    nx          = mag_inexact;
                end
            end
        end else begin
            if (op_sign) begin
                if (is_big || (mag != 32'd0)) begin
                    nv = 1'b1;
                end else begin
                    nx = mag_inexact;
                end
            end else begin
                if (is_big) begin
                    conv_result = 32'hFFFF_FFFF;
                    nv          = 1'b1;
                end else begin
                    conv_result = mag;
                    nx          = mag_inexact;
                end
            end
        end

        conv_fflags = {nv, 3'b000, nx};
    end

    // Valid bits and the S2 result register; flush overrides accept and advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_result  <= 32'd0;
            out_fflags  <= 5'd0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_move) begin
                s2_valid    <= 1'b1;
                out_result  <= conv_result;
                out_fflags  <= conv_fflags;
                out_illegal <= conv_illegal;
                out_tag     <= s1_tag;
            end else if (s2_free) begin
                s2_valid <= 1'b0;
            end

            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S1 operand capture; contents only meaningful while s1_valid is set
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= in_op;
            s1_rm  <= in_eff_rm;
            s1_uns <= in_unsigned;
            s1_tag <= in_tag;
        end
    end

endmodule

// File: tb/tb_fcvt_w_pipe.sv
// tb_fcvt_w_pipe: directed cases plus randomized traffic against a
// value-level reference model of float-to-integer conversion.
module tb_fcvt_w_pipe;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_op;
    logic [2:0]       in_rm;
    logic [2:0]       in_frm;
    logic             in_unsigned;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [4:0]       out_fflags;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    int compared;
    int mismatched;

    logic [37+TAG_W:0] exp_q[$];

    fcvt_w_pipe #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rm       (in_rm),
        .in_frm      (in_frm),
        .in_unsigned (in_unsigned),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_fflags  (out_fflags),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: exact value sig * 2^pw, rounded as a signed number in the
    // requested direction, then range-checked. Returns {illegal, fflags, result}.
    function automatic logic [37:0] ref_model(input logic [31:0] op, input logic [2:0] rm,
                                              input logic [2:0] frm, input logic uns);
        logic [2:0]  mode;
        logic        s;
        int          e;
        longint      sig, pw, flo, rem, half, mag, v;
        bit          huge, inexact, up, nv;
        logic [31:0] res;
        mode = (rm == 3'b111) ? frm : rm;
        if (mode > 3'd4) return {1'b1, 5'b00000, 32'd0};
        s = op[31];
        e = int'(op[30:23]);
        if (e == 255 && op[22:0] != 23'd0)
            return {1'b0, 5'b10000, (uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF)};
        huge = (e == 255);
        flo  = 0;
        rem  = 0;
        half = 1;
        if (!huge) begin
            sig = {41'd0, op[22:0]};
            if (e != 0) sig = sig + 64'sd8388608;
            pw = (e == 0) ? -64'sd149 : longint'(e) - 64'sd150;
            if (pw >= 0) begin
                if (pw > 10) huge = 1;
                else flo = sig << pw;
            end else if (-pw > 40) begin
                flo  = 0;
                rem  = sig;
                half = 64'sd1 << 40;
            end else begin
                flo  = sig >> (-pw);
                rem  = sig - (flo << (-pw));
                half = 64'sd1 << (-pw - 1);
            end
        end
        inexact = (rem != 0);
        case (mode)
            3'd0:    up = (rem > half) || ((rem == half) && flo[0]);
            3'd1:    up = 0;
            3'd2:    up = s && inexact;
            3'd3:    up = !s && inexact;
            default: up = inexact && (rem >= half);
        endcase
        mag = flo + (up ? 64'sd1 : 64'sd0);
        v   = s ? -mag : mag;
        nv  = 0;
        res = 32'd0;
        if (!uns) begin
            if (huge) begin
                nv = 1; res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else if (v > 64'sd2147483647) begin
                nv = 1; res = 32'h7FFF_FFFF;
            end else if (v < -64'sd2147483648) begin
                nv = 1; res = 32'h8000_0000;
            end else begin
                res = v[31:0];
            end
        end else begin
            if (huge) begin
                nv = 1; res = s ? 32'd0 : 32'hFFFF_FFFF;
            end else if (v < 0) begin
                nv = 1; res = 32'd0;
            end else if (v > 64'sd4294967295) begin
                nv = 1; res = 32'hFFFF_FFFF;
            end else begin
                res = v[31:0];
            end
        end
        return {1'b0, nv, 3'b000, (!nv && inexact), res};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 9))
            0:       return $urandom;
            7:       e = 8'd0;
            8:       e = 8'hFF;
            9:       e = 8'($urandom_range(150, 160));
            default: e = 8'($urandom_range(110, 165));
        endcase
        m = 23'($urandom);
        case ($urandom_range(0, 3))
            0:       m = 23'd0;
            1:       m[15:0] = 16'd0;
            default: ;
        endcase
        return {1'($urandom), e, m};
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] op, input logic [2:0] rm,
                                 input logic [2:0] frm, input logic uns, input logic [31:0] exp_res,
                                 input logic [4:0] exp_flags, input logic exp_ill);
        @(posedge clk); #1;
        in_valid    = 1'b1;
        in_op       = op;
        in_rm       = rm;
        in_frm      = frm;
        in_unsigned = uns;
        in_tag      = 5'd7;
        out_ready   = 1'b1;
        #1;
        checkOutput({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        checkOutput({tag, "_vld"}, out_valid, 1);
        checkOutput({tag, "_res"}, out_result, exp_res);
        checkOutput({tag, "_flags"}, out_fflags, exp_flags);
        checkOutput({tag, "_ill"}, out_illegal, exp_ill);
        checkOutput({tag, "_tag"}, out_tag, 5'd7);
    endtask

    task automatic pop_and_check();
        logic [37+TAG_W:0] e;
        if (exp_q.size() == 0) begin
            checkOutput("rand_spurious", out_valid, 0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("rand_res", out_result, e[31:0]);
            checkOutput("rand_flags_ill", {out_illegal, out_fflags}, e[37:32]);
            checkOutput("rand_tag", out_tag, e[37+TAG_W:38]);
        end
    endtask

    initial begin
        int accepts;
        bit saw;
        bit do_flush;
        logic [2:0] r;
        compared    = 0;
        mismatched  = 0;
        accepts     = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_op       = 32'd0;
        in_rm       = 3'd0;
        in_frm      = 3'd0;
        in_unsigned = 1'b0;
        in_tag      = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_vld", out_valid, 0);
        checkOutput("reset_rdy", in_ready, 1);
        checkOutput("reset_res", out_result, 0);
        checkOutput("reset_tag", out_tag, 0);

        applyStimulus("p25_rne", 32'h40200000, 3'b000, 3'b000, 1'b0, 32'h00000002, 5'h01, 1'b0);
        applyStimulus("p25_rmm", 32'h40200000, 3'b100, 3'b000, 1'b0, 32'h00000003, 5'h01, 1'b0);
        applyStimulus("p25_rtz", 32'h40200000, 3'b001, 3'b000, 1'b0, 32'h00000002, 5'h01, 1'b0);
        applyStimulus("n25_rdn", 32'hC0200000, 3'b010, 3'b000, 1'b0, 32'hFFFFFFFD, 5'h01, 1'b0);
        applyStimulus("n25_rup", 32'hC0200000, 3'b011, 3'b000, 1'b0, 32'hFFFFFFFE, 5'h01, 1'b0);
        applyStimulus("n25_dyn", 32'hC0200000, 3'b111, 3'b010, 1'b0, 32'hFFFFFFFD, 5'h01, 1'b0);
        applyStimulus("p2_31_s", 32'h4F000000, 3'b000, 3'b000, 1'b0, 32'h7FFFFFFF, 5'h10, 1'b0);
        applyStimulus("p2_31_u", 32'h4F000000, 3'b000, 3'b000, 1'b1, 32'h80000000, 5'h00, 1'b0);
        applyStimulus("n2_31_s", 32'hCF000000, 3'b000, 3'b000, 1'b0, 32'h80000000, 5'h00, 1'b0);
        applyStimulus("pinf_u",  32'h7F800000, 3'b000, 3'b000, 1'b1, 32'hFFFFFFFF, 5'h10, 1'b0);
        applyStimulus("nan_s",   32'h7FC00000, 3'b000, 3'b000, 1'b0, 32'h7FFFFFFF, 5'h10, 1'b0);
        applyStimulus("m1_u",    32'hBF800000, 3'b000, 3'b000, 1'b1, 32'h00000000, 5'h10, 1'b0);
        applyStimulus("mq_u",    32'hBE800000, 3'b001, 3'b000, 1'b1, 32'h00000000, 5'h01, 1'b0);
        applyStimulus("sub_rup", 32'h00000001, 3'b011, 3'b000, 1'b0, 32'h00000001, 5'h01, 1'b0);
        applyStimulus("ill_rm",  32'h40200000, 3'b101, 3'b000, 1'b0, 32'h00000000, 5'h00, 1'b1);

        // Backpressure: three ops against a stalled consumer
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_rm = 3'b001; in_frm = 3'b000; in_unsigned = 1'b0;
        in_op = 32'h3F800000; in_tag = 5'd1;
        #1; checkOutput("bp_rdy1", in_ready, 1);
        @(posedge clk); #1;
        in_op = 32'h40000000; in_tag = 5'd2;
        #1; checkOutput("bp_rdy2", in_ready, 1);
        @(posedge clk); #1;
        in_op = 32'h40400000; in_tag = 5'd3;
        #1; checkOutput("bp_rdy3", in_ready, 0);
        checkOutput("bp_vld3", out_valid, 1);
        checkOutput("bp_tag3", out_tag, 1);
        @(posedge clk); #2;
        checkOutput("bp_hold_rdy", in_ready, 0);
        checkOutput("bp_hold_tag", out_tag, 1);
        checkOutput("bp_hold_res", out_result, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1; checkOutput("bp_rel_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        checkOutput("bp_d2_vld", out_valid, 1);
        checkOutput("bp_d2_tag", out_tag, 2);
        checkOutput("bp_d2_res", out_result, 2);
        @(posedge clk); #2;
        checkOutput("bp_d3_vld", out_valid, 1);
        checkOutput("bp_d3_tag", out_tag, 3);
        checkOutput("bp_d3_res", out_result, 3);
        @(posedge clk); #2;
        checkOutput("bp_empty", out_valid, 0);

        // Flush with two ops in flight and a third offered
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_op = 32'h40200000; in_rm = 3'b000; in_tag = 5'd4;
        @(posedge clk); #1;
        in_tag = 5'd5;
        @(posedge clk); #1;
        in_tag = 5'd6; flush = 1'b1;
        #1; checkOutput("flush_pre_vld", out_valid, 1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checkOutput("flush_vld", out_valid, 0);
        checkOutput("flush_rdy", in_ready, 1);
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
            if (out_valid) saw = 1'b1;
        end
        checkOutput("flush_no_result", saw, 0);

        // Synchronous reset in the middle of a stall
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_op = 32'h40200000; in_rm = 3'b000; in_tag = 5'd9;
        @(posedge clk); #1;
        in_tag = 5'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        checkOutput("stall_rdy", in_ready, 0);
        checkOutput("stall_vld", out_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_vld", out_valid, 0);
        checkOutput("rst_res", out_result, 0);
        checkOutput("rst_flags", out_fflags, 0);
        checkOutput("rst_ill", out_illegal, 0);
        checkOutput("rst_tag", out_tag, 0);
        checkOutput("rst_rdy", in_ready, 1);

        // Randomized traffic against the reference model
        exp_q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            do_flush    = ($urandom_range(0, 49) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_op       = rand_op();
            r           = 3'($urandom_range(0, 9));
            if (r < 3'd6)       in_rm = 3'($urandom_range(0, 4));
            else if (r < 3'd7)  in_rm = 3'b111;
            else                in_rm = 3'($urandom_range(5, 6));
            in_frm      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            in_unsigned = 1'($urandom);
            in_tag      = TAG_W'($urandom);
            out_ready   = do_flush ? 1'b0 : ($urandom_range(0, 9) < 7);
            flush       = do_flush;
            #1;
            if (do_flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) pop_and_check();
                if (in_valid && in_ready) begin
                    accepts++;
                    exp_q.push_back({in_tag, ref_model(in_op, in_rm, in_frm, in_unsigned)});
                end
            end
        end

        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int d = 0; d < 8; d++) begin
            #1;
            if (out_valid) pop_and_check();
            @(posedge clk); #1;
        end
        checkOutput("drain_empty", exp_q.size(), 0);
        checkOutput("rand_accepts", (accepts > 1000), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
